input_conditioner: RTL
======================

Name: input_conditioner

Overview:
Front-end stage that feeds the computer core. It takes the raw, asynchronous pins from the reed sensors (nFork, nCrank) and the push-buttons (nMode, nTrip) and produces synchronised, debounced active-low levels for the core, plus single-cycle event strobes. For buttons it classifies each press as short or long, so the downstream logic never sees contact bounce or metastable inputs.

Parameters:
DEBOUNCE_CYC, 164, consecutive stable cycles needed before a clean level changes (~5 ms at 32.768 kHz).
HOLDOFF_CYC, 655, cycles after an accepted sensor falling edge during which that sensor channel ignores all input (~20 ms).
LONG_CYC, 65536, cycles a button must stay held to count as a long press (2 s).
CW, 17, counter width; must satisfy 2^CW > max(DEBOUNCE_CYC, HOLDOFF_CYC, LONG_CYC).

Ports:
Clock  in  1  system clock; all state on rising edge
nReset  in  1  asynchronous active-low reset
nFork  in  1  raw wheel reed switch, active low
nCrank  in  1  raw crank reed switch, active low
nMode  in  1  raw mode button, active low
nTrip  in  1  raw trip button, active low
nFork_c  out  1  clean fork level, active low
nCrank_c  out  1  clean crank level, active low
nMode_c  out  1  clean mode level, active low
nTrip_c  out  1  clean trip level, active low
fork_pulse  out  1  one-cycle strobe per accepted fork falling edge
crank_pulse  out  1  one-cycle strobe per accepted crank falling edge
mode_short  out  1  one-cycle strobe: mode released before LONG_CYC
trip_short  out  1  one-cycle strobe: trip released before LONG_CYC
mode_long  out  1  one-cycle strobe: mode held LONG_CYC cycles
trip_long  out  1  one-cycle strobe: trip held LONG_CYC cycles
combo_long  out  1  one-cycle strobe: both buttons held together LONG_CYC cycles

Behaviour:
- Reset (async assert, sync-released by Clock): sync flops = 1; clean levels = 1; all counters = 0; all strobes = 0; button FSMs = IDLE. If reset is asserted mid-count or mid-press, the event is lost and no strobe is emitted after release.
- Synchroniser: two flops per input. A raw change at edge t is visible at the sync output at t+2.
- Debounce, per channel: counter compares the sync value with the clean value. On mismatch it increments; any cycle of agreement clears it to 0. When the counter reaches DEBOUNCE_CYC, the clean value takes the sync value and the counter clears. Total latency from raw edge to clean edge = 2+DEBOUNCE_CYC cycles.
- Sensor strobe: fork_pulse/crank_pulse are asserted in the same cycle the clean level goes 1->0, registered and coincident with the clean output.
- Sensor holdoff: after an accepted falling edge, a holdoff counter runs for HOLDOFF_CYC cycles. During holdoff the debounce counter is held at 0 and the clean level is frozen. When holdoff ends, normal debounce resumes against the current sync value, so a level already high is accepted after DEBOUNCE_CYC more cycles.
- Button FSM, per button:
  - IDLE: clean falling edge -> PRESSED, press counter = 0.
  - PRESSED: counter increments each cycle. Clean rising edge with counter < LONG_CYC -> emit *_short, go to IDLE. Counter reaches LONG_CYC -> emit *_long, go to WAIT_REL.
  - WAIT_REL: clean rising edge -> IDLE; no further strobes.
- Combo: if both clean button levels are low simultaneously, a shared combo counter runs. At LONG_CYC it emits combo_long and forces both button FSMs to WAIT_REL, which suppresses the individual long/short strobes. Either button rising before LONG_CYC clears the combo counter; the individual FSMs then continue normally.
- Counters saturate; none wraps.
- Each strobe fires at most one per event and is never asserted for two consecutive cycles.

Test Plan:
Bench uses DEBOUNCE_CYC=4, HOLDOFF_CYC=10, LONG_CYC=20.
- Reset: hold nReset=0 with random inputs, then release -> all clean outputs=1, all strobes=0, no strobe in the next 30 cycles with inputs idle high.
- Bounce: nFork toggles 0/1/0/1 every 2 cycles, then stays 0 -> a single fork_pulse 6 cycles after the final fall; nFork_c=0 from that cycle.
- Holdoff: clean fork fall accepted, then nFork bounces high and low for 8 cycles -> exactly one fork_pulse; a second fall 30 cycles later -> a second pulse.
- Short press: nMode low for 10 cycles, then high -> mode_short once, 6 cycles after release; mode_long=0.
- Long press: nTrip low for 40 cycles -> trip_long once, 26 cycles after the press; no trip_short on release.
- Combo: both buttons low for 40 cycles -> combo_long once; no mode_long, trip_long, or short strobes. Asserting nReset mid-hold -> no strobe at all.

Source files
------------

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - sync, debounce, sensor holdoff and button press classification

module ic_channel #(
    parameter int unsigned DEBOUNCE_CYC = 164,
    parameter int unsigned HOLDOFF_CYC  = 0,
    parameter int unsigned CW           = 17
) (
    input  logic Clock,
    input  logic nReset,
    input  logic raw_i,
    output logic clean_o,
    output logic clean_nxt_o
);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYC);

    logic          meta_q, sync_q;
    logic          clean_q, clean_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [CW-1:0] hold_q, hold_d;

    // While holdoff runs the channel is deaf: debounce stays cleared, level frozen.
    always_comb begin
        clean_d = clean_q;
        deb_d   = '0;
        hold_d  = hold_q;
        if (hold_q != '0) begin
            hold_d = hold_q - CW'(1);
        end else if (sync_q != clean_q) begin
            if (deb_q == DEB_LAST) begin
                clean_d = sync_q;
                if (!sync_q) begin
                    hold_d = HOLD_LOAD;
                end
            end else begin
                deb_d = deb_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            clean_q <= 1'b1;
            deb_q   <= '0;
            hold_q  <= '0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            clean_q <= clean_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
        end
    end

    assign clean_o     = clean_q;
    assign clean_nxt_o = clean_d;
endmodule

module ic_button #(
    parameter int unsigned LONG_CYC = 65536,
    parameter int unsigned CW       = 17
) (
    input  logic Clock,
    input  logic nReset,
    input  logic fall_i,
    input  logic rise_i,
    input  logic combo_fire_i,
    output logic short_o,
    output logic long_o
);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESSED,
        BTN_WAIT_REL
    } btn_state_e;

    btn_state_e    state_q, state_d;
    logic [CW-1:0] press_q, press_d;
    logic          short_q, short_d;
    logic          long_q, long_d;

    always_comb begin
        state_d = state_q;
        press_d = press_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            BTN_IDLE: begin
                if (fall_i) begin
                    state_d = BTN_PRESSED;
                    press_d = '0;
                end
            end
            BTN_PRESSED: begin
                if (rise_i) begin
                    short_d = 1'b1;
                    state_d = BTN_IDLE;
                end else if (press_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = BTN_WAIT_REL;
                end else begin
                    press_d = press_q + CW'(1);
                end
            end
            BTN_WAIT_REL: begin
                if (rise_i) begin
                    state_d = BTN_IDLE;
                end
            end
            default: state_d = BTN_IDLE;
        endcase
        // A combo hold owns both buttons until they are released.
        if (combo_fire_i) begin
            state_d = BTN_WAIT_REL;
            short_d = 1'b0;
            long_d  = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= BTN_IDLE;
            press_q <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    assign short_o = short_q;
    assign long_o  = long_q;
endmodule

module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYC = 164,
    parameter int unsigned HOLDOFF_CYC  = 655,
    parameter int unsigned LONG_CYC     = 65536,
    parameter int unsigned CW           = 17
) (
    input  logic Clock,
    input  logic nReset,
    input  logic nFork,
    input  logic nCrank,
    input  logic nMode,
    input  logic nTrip,
    output logic nFork_c,
    output logic nCrank_c,
    output logic nMode_c,
    output logic nTrip_c,
    output logic fork_pulse,
    output logic crank_pulse,
    output logic mode_short,
    output logic trip_short,
    output logic mode_long,
    output logic trip_long,
    output logic combo_long
);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYC);

    logic          fork_nxt, crank_nxt, mode_nxt, trip_nxt;
    logic          mode_fall, mode_rise, trip_fall, trip_rise;
    logic          both_held, combo_fire;
    logic [CW-1:0] combo_q, combo_d;
    logic          fork_pulse_q, crank_pulse_q, combo_long_q;

    ic_channel #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLDOFF_CYC(HOLDOFF_CYC), .CW(CW)) u_fork (
        .Clock(Clock), .nReset(nReset), .raw_i(nFork), .clean_o(nFork_c), .clean_nxt_o(fork_nxt));
    ic_channel #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLDOFF_CYC(HOLDOFF_CYC), .CW(CW)) u_crank (
        .Clock(Clock), .nReset(nReset), .raw_i(nCrank), .clean_o(nCrank_c), .clean_nxt_o(crank_nxt));
    ic_channel #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLDOFF_CYC(0), .CW(CW)) u_mode (
        .Clock(Clock), .nReset(nReset), .raw_i(nMode), .clean_o(nMode_c), .clean_nxt_o(mode_nxt));
    ic_channel #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLDOFF_CYC(0), .CW(CW)) u_trip (
        .Clock(Clock), .nReset(nReset), .raw_i(nTrip), .clean_o(nTrip_c), .clean_nxt_o(trip_nxt));

    assign mode_fall = nMode_c & ~mode_nxt;
    assign mode_rise = ~nMode_c & mode_nxt;
    assign trip_fall = nTrip_c & ~trip_nxt;
    assign trip_rise = ~nTrip_c & trip_nxt;
    assign both_held = ~nMode_c & ~nTrip_c & ~mode_rise & ~trip_rise;

    // Combo counter parks at LONG_CYC so one hold fires exactly once.
    always_comb begin
        combo_d    = '0;
        combo_fire = 1'b0;
        if (both_held) begin
            if (combo_q == LONG_LAST) begin
                combo_fire = 1'b1;
                combo_d    = LONG_SAT;
            end else if (combo_q == LONG_SAT) begin
                combo_d = LONG_SAT;
            end else begin
                combo_d = combo_q + CW'(1);
            end
        end
    end

    ic_button #(.LONG_CYC(LONG_CYC), .CW(CW)) u_mode_btn (
        .Clock(Clock), .nReset(nReset), .fall_i(mode_fall), .rise_i(mode_rise),
        .combo_fire_i(combo_fire), .short_o(mode_short), .long_o(mode_long));
    ic_button #(.LONG_CYC(LONG_CYC), .CW(CW)) u_trip_btn (
        .Clock(Clock), .nReset(nReset), .fall_i(trip_fall), .rise_i(trip_rise),
        .combo_fire_i(combo_fire), .short_o(trip_short), .long_o(trip_long));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            combo_q       <= '0;
            fork_pulse_q  <= 1'b0;
            crank_pulse_q <= 1'b0;
            combo_long_q  <= 1'b0;
        end else begin
            combo_q       <= combo_d;
            fork_pulse_q  <= nFork_c & ~fork_nxt;
            crank_pulse_q <= nCrank_c & ~crank_nxt;
            combo_long_q  <= combo_fire;
        end
    end

    assign fork_pulse  = fork_pulse_q;
    assign crank_pulse = crank_pulse_q;
    assign combo_long  = combo_long_q;
endmodule
